// File: rtl/sort_pkg.sv
// Shared constants and types for the 4-input sorter and its frame collector.
package sort_pkg;

  localparam int SORT_W = 8;
  localparam int SORT_N = 4;

  localparam logic [SORT_W-1:0] SORT_PAD = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } sort_state_t;

endpackage

// File: rtl/sort_idle_timer.sv
// Loadable saturating up-counter with synchronous clear and a terminal-count flag.
module sort_idle_timer #(
  parameter int WIDTH = 5,
  parameter int SAT   = 16,
  parameter int TERM  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] SAT_V  = WIDTH'(SAT);
  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

  logic [WIDTH-1:0] count;

  // Clear has priority over load; counting stops at SAT instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != SAT_V)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = (count == TERM_V);

endmodule

// File: rtl/sort_frame_collector.sv
// Packs a valid/ready byte stream into 4-slot frames for the sorter, padding
// a stalled partial frame with PAD once it has sat idle for TIMEOUT cycles.
module sort_frame_collector
  import sort_pkg::*;
#(
  parameter int           W       = SORT_W,
  parameter int           TIMEOUT = 16,
  parameter logic [W-1:0] PAD     = W'(SORT_PAD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         frm_valid,
  input  logic         frm_ready,
  output logic         frm_padded,
  output logic [1:0]   pad_cnt
);

  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TERM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  sort_state_t  state, next_state;
  logic [1:0]   idx;
  logic [W-1:0] slot [SORT_N];
  logic         accept;
  logic         timeout_fire;
  logic         idle_clear;
  logic         idle_enable;
  logic         idle_terminal;

  assign in_ready = reset && (state != HOLD);
  assign accept   = in_valid && in_ready;

  // The timer only runs while a partial frame waits; any accept restarts it.
  assign idle_clear   = accept || (state != COLLECT);
  assign idle_enable  = (state == COLLECT);
  assign timeout_fire = (TIMEOUT > 0) && (state == COLLECT) && !accept && idle_terminal;

  sort_idle_timer #(
    .WIDTH (TW),
    .SAT   (TIMEOUT),
    .TERM  (TERM)
  ) u_idle_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (idle_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (idle_enable),
    .terminal   (idle_terminal)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = COLLECT;
      COLLECT: if ((accept && (idx == 2'd3)) || timeout_fire) next_state = HOLD;
      HOLD:    if (frm_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Accept beats timeout, so a byte landing on the terminal cycle completes the frame unpadded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      frm_padded <= 1'b0;
      pad_cnt    <= 2'd0;
      for (int i = 0; i < SORT_N; i++) slot[i] <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE, COLLECT: begin
          if (accept) begin
            slot[idx]  <= in_data;
            idx        <= idx + 2'd1;
            frm_padded <= 1'b0;
            pad_cnt    <= 2'd0;
          end else if (timeout_fire) begin
            for (int i = 0; i < SORT_N; i++) begin
              if (2'(i) >= idx) slot[i] <= PAD;
            end
            idx        <= 2'd0;
            frm_padded <= 1'b1;
            pad_cnt    <= 2'(3'(SORT_N) - {1'b0, idx});
          end
        end
        HOLD: begin
          if (frm_ready) begin
            idx        <= 2'd0;
            frm_padded <= 1'b0;
            pad_cnt    <= 2'd0;
          end
        end
        default: idx <= 2'd0;
      endcase
    end
  end

  assign a         = slot[0];
  assign b         = slot[1];
  assign c         = slot[2];
  assign d         = slot[3];
  assign frm_valid = (state == HOLD);

endmodule

// File: tb/tb_sort_frame_collector.sv
// Self-checking bench for sort_frame_collector: directed vector table, hand-built
// timeout/reset sequences, and a randomized run against a frame-level model.
module tb_sort_frame_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, c, d;
  logic       frm_valid;
  logic       frm_ready;
  logic       frm_padded;
  logic [1:0] pad_cnt;

  logic       in_valid0;
  logic       in_ready0;
  logic [7:0] a0, b0, c0, d0;
  logic       frm_valid0;
  logic       frm_padded0;
  logic [1:0] pad_cnt0;

  int passed = 0;
  int total  = 0;

  sort_frame_collector #(.W(8), .TIMEOUT(16), .PAD(8'hFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .frm_valid  (frm_valid),
    .frm_ready  (frm_ready),
    .frm_padded (frm_padded),
    .pad_cnt    (pad_cnt)
  );

  sort_frame_collector #(.W(8), .TIMEOUT(0), .PAD(8'hFF)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid0),
    .in_ready   (in_ready0),
    .a          (a0),
    .b          (b0),
    .c          (c0),
    .d          (d0),
    .frm_valid  (frm_valid0),
    .frm_ready  (frm_ready),
    .frm_padded (frm_padded0),
    .pad_cnt    (pad_cnt0)
  );

  always #5 clk = ~clk;

  // Directed vector: inputs for one cycle and the outputs expected during it.
  typedef struct {
    bit         rst;
    bit         v;
    logic [7:0] d;
    bit         fr;
    bit         rdy;
    bit         val;
    bit         chk;
    logic [7:0] ea, eb, ec, ed;
    bit         pad;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit v, logic [7:0] dd, bit fr, bit rdy, bit val, bit chk,
                              logic [7:0] ea, logic [7:0] eb, logic [7:0] ec, logic [7:0] ed,
                              bit pad, logic [1:0] cnt);
    vec_t t;
    t.rst = rst; t.v = v; t.d = dd; t.fr = fr;
    t.rdy = rdy; t.val = val; t.chk = chk;
    t.ea = ea; t.eb = eb; t.ec = ec; t.ed = ed;
    t.pad = pad; t.cnt = cnt;
    return t;
  endfunction

  // Frame-level reference model: a queue of bytes in the current frame and the held frame.
  logic [7:0] m_q[$];
  int         m_idle;
  bit         m_held;
  logic [7:0] m_frame[4];
  bit         m_pad;
  int         m_cnt;
  localparam int M_TIMEOUT = 16;

  function automatic void modelReset();
    m_q.delete();
    m_idle = 0;
    m_held = 0;
    m_pad  = 0;
    m_cnt  = 0;
  endfunction

  function automatic void modelStep(bit rst, bit v, logic [7:0] dd, bit fr);
    if (!rst) begin
      modelReset();
    end else if (m_held) begin
      if (fr) begin
        m_held = 0;
        m_pad  = 0;
        m_cnt  = 0;
      end
    end else if (v) begin
      m_q.push_back(dd);
      m_idle = 0;
      if (m_q.size() == 4) begin
        for (int i = 0; i < 4; i++) m_frame[i] = m_q[i];
        m_held = 1;
        m_pad  = 0;
        m_cnt  = 0;
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle == M_TIMEOUT) begin
        for (int i = 0; i < 4; i++) m_frame[i] = (i < m_q.size()) ? m_q[i] : 8'hFF;
        m_cnt  = 4 - m_q.size();
        m_pad  = 1;
        m_held = 1;
        m_idle = 0;
        m_q.delete();
      end
    end
  endfunction

  task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] dd, input bit fr);
    reset     = rst;
    in_valid  = v;
    in_data   = dd;
    frm_ready = fr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Drive one cycle's inputs after the falling edge, then let outputs settle for sampling.
  task automatic step(input bit rst, input bit v, input logic [7:0] dd, input bit fr);
    @(negedge clk);
    applyStimulus(rst, v, dd, fr);
    #1;
  endtask

  task automatic checkFrame(input string name, input logic [7:0] ea, input logic [7:0] eb,
                            input logic [7:0] ec, input logic [7:0] ed);
    checkOutput({name, "_a"}, a, ea);
    checkOutput({name, "_b"}, b, eb);
    checkOutput({name, "_c"}, c, ec);
    checkOutput({name, "_d"}, d, ed);
  endtask

  int  n;
  bit  seen_valid0;
  int  p_valid;
  bit  r_rst, r_v, r_fr;
  logic [7:0] r_d;

  initial begin
    in_valid0 = 1'b0;
    applyStimulus(0, 0, 8'h00, 0);
    repeat (2) @(posedge clk);

    // Basic frame, one-cycle hold with frm_ready high, then a stalled frame.
    vecs.push_back(mk(0,0,8'h00,0, 0,0,1, 8'h00,8'h00,8'h00,8'h00, 0,0));
    vecs.push_back(mk(1,1,8'h40,1, 1,0,1, 8'h00,8'h00,8'h00,8'h00, 0,0));
    vecs.push_back(mk(1,1,8'h10,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0));
    vecs.push_back(mk(1,1,8'h30,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0));
    vecs.push_back(mk(1,1,8'h20,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0));
    vecs.push_back(mk(1,0,8'h00,1, 0,1,1, 8'h40,8'h10,8'h30,8'h20, 0,0));
    vecs.push_back(mk(1,0,8'h00,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0));
    vecs.push_back(mk(1,1,8'h40,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0));
    vecs.push_back(mk(1,1,8'h10,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0));
    vecs.push_back(mk(1,1,8'h30,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0));
    vecs.push_back(mk(1,1,8'h20,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,1,8'h99,0, 0,1,1, 8'h40,8'h10,8'h30,8'h20, 0,0));
    vecs.push_back(mk(1,1,8'h99,1, 0,1,1, 8'h40,8'h10,8'h30,8'h20, 0,0));
    vecs.push_back(mk(1,0,8'h00,0, 1,0,1, 8'h40,8'h10,8'h30,8'h20, 0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].fr);
      checkOutput($sformatf("vec%0d_ready", i), in_ready, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_valid", i), frm_valid, vecs[i].val);
      checkOutput($sformatf("vec%0d_padded", i), frm_padded, vecs[i].pad);
      checkOutput($sformatf("vec%0d_padcnt", i), pad_cnt, vecs[i].cnt);
      if (vecs[i].chk) checkFrame($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed);
    end

    // Two bytes then silence: padded frame appears 16 idle cycles later.
    step(1, 1, 8'h05, 0);
    step(1, 1, 8'h07, 0);
    n = 0;
    step(1, 0, 8'h00, 0);
    while (!frm_valid && n < 40) begin
      n++;
      step(1, 0, 8'h00, 0);
    end
    checkOutput("timeout_latency", n, 16);
    checkOutput("timeout_valid", frm_valid, 1);
    checkOutput("timeout_ready", in_ready, 0);
    checkFrame("timeout", 8'h05, 8'h07, 8'hFF, 8'hFF);
    checkOutput("timeout_padded", frm_padded, 1);
    checkOutput("timeout_padcnt", pad_cnt, 2);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);
    checkOutput("timeout_release_valid", frm_valid, 0);
    checkOutput("timeout_release_padded", frm_padded, 0);
    checkOutput("timeout_release_padcnt", pad_cnt, 0);

    // Fourth byte lands on the terminal idle cycle: accept wins over padding.
    step(1, 1, 8'h11, 0);
    step(1, 1, 8'h22, 0);
    step(1, 1, 8'h33, 0);
    repeat (15) step(1, 0, 8'h00, 0);
    step(1, 1, 8'h44, 0);
    checkOutput("race_pre_valid", frm_valid, 0);
    checkOutput("race_pre_ready", in_ready, 1);
    step(1, 0, 8'h00, 1);
    checkOutput("race_valid", frm_valid, 1);
    checkFrame("race", 8'h11, 8'h22, 8'h33, 8'h44);
    checkOutput("race_padded", frm_padded, 0);
    checkOutput("race_padcnt", pad_cnt, 0);
    step(1, 0, 8'h00, 0);

    // Reset in the middle of a frame discards it.
    step(1, 1, 8'hAA, 0);
    step(1, 1, 8'hBB, 0);
    step(0, 1, 8'hCC, 0);
    checkOutput("midreset_ready_low", in_ready, 0);
    step(1, 0, 8'h00, 0);
    checkOutput("midreset_valid", frm_valid, 0);
    checkOutput("midreset_ready", in_ready, 1);
    checkFrame("midreset", 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("midreset_padded", frm_padded, 0);
    for (int i = 1; i <= 4; i++) step(1, 1, 8'(i), 0);
    step(1, 0, 8'h00, 1);
    checkOutput("postreset_valid", frm_valid, 1);
    checkFrame("postreset", 8'h01, 8'h02, 8'h03, 8'h04);
    checkOutput("postreset_padded", frm_padded, 0);
    step(1, 0, 8'h00, 0);

    // TIMEOUT=0 instance never pads a lone byte.
    step(1, 0, 8'h5A, 0);
    in_valid0 = 1'b1;
    step(1, 0, 8'h00, 0);
    in_valid0 = 1'b0;
    seen_valid0 = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 8'h00, 0);
      if (frm_valid0 !== 1'b0 || in_ready0 !== 1'b1) seen_valid0 = 1;
    end
    checkOutput("notimeout_never_valid", seen_valid0, 0);
    checkOutput("notimeout_a", a0, 8'h5A);
    checkOutput("notimeout_bcd", {b0, c0, d0}, 24'h0);
    checkOutput("notimeout_padded", {frm_padded0, pad_cnt0}, 0);

    // Randomized run against the frame-level model.
    step(0, 0, 8'h00, 0);
    modelReset();
    p_valid = 90;
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: p_valid = 90;
          1: p_valid = 50;
          default: p_valid = 3;
        endcase
      end
      r_rst = ($urandom_range(0, 499) != 0);
      r_v   = ($urandom_range(0, 99) < p_valid);
      r_d   = 8'($urandom);
      r_fr  = ($urandom_range(0, 3) != 0);
      step(r_rst, r_v, r_d, r_fr);
      checkOutput("rnd_ready", in_ready, r_rst && !m_held);
      checkOutput("rnd_valid", frm_valid, m_held);
      checkOutput("rnd_padded", frm_padded, m_pad);
      checkOutput("rnd_padcnt", pad_cnt, m_cnt);
      if (m_held) checkFrame("rnd", m_frame[0], m_frame[1], m_frame[2], m_frame[3]);
      modelStep(r_rst, r_v, r_d, r_fr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
